// File: rtl/decrypt_stream.sv
// Purpose: strips the 32-bit XOR keystream from AXI4-Stream packets (receive-side twin of the encryption stage).
// Latency: 1 cycle; a word accepted at edge N is presented on m_axis in cycle N+1.
// Backpressure: 2-entry main/skid buffer; s_axis_tready is registered and drops only when both entries are full.
//
// Ports:
//   axi_aclk, axi_areset            clock, asynchronous active-high reset
//   s_axis_t{data,strb,user,valid,last}, s_axis_tready   upstream stream
//   m_axis_t{data,strb,user,valid,last}, m_axis_tready   downstream stream
//   key, decrypt_en                 per-packet key and enable, sampled on the first word
//   pkt_count, word_count           decrypted-packet and emitted-word counters (wrap at 2^32)
module decrypt_stream #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH   = 32
) (
    input  logic                              axi_aclk,
    input  logic                              axi_areset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     key,
    input  logic                              decrypt_en,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     pkt_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     word_count
);

    localparam int HDR2_W = 240;

    typedef enum logic [1:0] {
        HDR1    = 2'd0,
        HDR2    = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t                            state_q, state_d;
    logic [C_S_AXI_DATA_WIDTH-1:0]     key_q;
    logic                              en_q;
    logic                              en_cur;
    logic                              s_hs, m_hs;
    logic [1:0]                        occ_q, occ_d;
    logic                              ready_q;
    logic                              load_main_in, load_main_skid, load_skid;
    logic [C_S_AXIS_DATA_WIDTH-1:0]    xdat;
    logic [C_S_AXIS_DATA_WIDTH-1:0]    pay_mask;
    logic [HDR2_W-1:0]                 hdr2_mask;

    logic [C_M_AXIS_DATA_WIDTH-1:0]    skid_dat;
    logic [C_M_AXIS_DATA_WIDTH/8-1:0]  skid_strb;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]   skid_user;
    logic                              skid_last;
    logic                              skid_en;
    logic                              main_en;

    assign s_hs          = s_axis_tvalid & ready_q;
    assign m_hs          = m_axis_tvalid & m_axis_tready;
    assign s_axis_tready = ready_q;
    assign m_axis_tvalid = (occ_q != 2'd0);

    // Header word 2 keeps its top 16 bits; the low 16 bits take the key's low half,
    // and the seven full key copies sit above them.
    assign hdr2_mask = {{7{key_q}}, key_q[15:0]};
    assign pay_mask  = {8{key_q}};

    // ---------------- input FSM ----------------
    always_comb begin
        state_d = state_q;
        if (s_hs) begin
            if (s_axis_tlast) begin
                state_d = HDR1;
            end else begin
                case (state_q)
                    HDR1:    state_d = HDR2;
                    HDR2:    state_d = PAYLOAD;
                    default: state_d = PAYLOAD;
                endcase
            end
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_q <= HDR1;
            key_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (s_hs && state_q == HDR1) begin
                key_q <= key;
                en_q  <= decrypt_en;
            end
        end
    end

    // ---------------- transform ----------------
    // The first word is never modified, so only its enable must come from the
    // live input (it is carried with the word for pkt_count).
    always_comb begin
        en_cur = (state_q == HDR1) ? decrypt_en : en_q;
        xdat   = s_axis_tdata;
        if (en_cur) begin
            case (state_q)
                HDR2:    xdat[HDR2_W-1:0] = s_axis_tdata[HDR2_W-1:0] ^ hdr2_mask;
                PAYLOAD: xdat = s_axis_tdata ^ pay_mask;
                default: ;
            endcase
        end
    end

    // ---------------- 2-entry output buffer ----------------
    always_comb begin
        occ_d          = occ_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (occ_q)
            2'd0: begin
                if (s_hs) begin
                    occ_d        = 2'd1;
                    load_main_in = 1'b1;
                end
            end
            2'd1: begin
                if (s_hs && m_hs) begin
                    load_main_in = 1'b1;
                end else if (s_hs) begin
                    occ_d     = 2'd2;
                    load_skid = 1'b1;
                end else if (m_hs) begin
                    occ_d = 2'd0;
                end
            end
            2'd2: begin
                // ready_q is low here, so only the drain side can move
                if (m_hs) begin
                    occ_d          = 2'd1;
                    load_main_skid = 1'b1;
                end
            end
            default: occ_d = 2'd0;
        endcase
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            occ_q        <= 2'd0;
            ready_q      <= 1'b0;
            m_axis_tdata <= '0;
            m_axis_tstrb <= '0;
            m_axis_tuser <= '0;
            m_axis_tlast <= 1'b0;
            main_en      <= 1'b0;
            skid_dat     <= '0;
            skid_strb    <= '0;
            skid_user    <= '0;
            skid_last    <= 1'b0;
            skid_en      <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            ready_q <= (occ_d != 2'd2);
            if (load_main_in) begin
                m_axis_tdata <= xdat;
                m_axis_tstrb <= s_axis_tstrb;
                m_axis_tuser <= s_axis_tuser;
                m_axis_tlast <= s_axis_tlast;
                main_en      <= en_cur;
            end else if (load_main_skid) begin
                m_axis_tdata <= skid_dat;
                m_axis_tstrb <= skid_strb;
                m_axis_tuser <= skid_user;
                m_axis_tlast <= skid_last;
                main_en      <= skid_en;
            end
            if (load_skid) begin
                skid_dat  <= xdat;
                skid_strb <= s_axis_tstrb;
                skid_user <= s_axis_tuser;
                skid_last <= s_axis_tlast;
                skid_en   <= en_cur;
            end
        end
    end

    // ---------------- counters ----------------
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            pkt_count  <= '0;
            word_count <= '0;
        end else if (m_hs) begin
            word_count <= word_count + 1'b1;
            if (m_axis_tlast && main_en) begin
                pkt_count <= pkt_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decrypt_stream.sv
// Purpose: randomized and directed bench for decrypt_stream with a queue scoreboard.
// Latency: checks the one-cycle accept-to-present latency where the sink is always ready.
// Backpressure: sink ready is driven always-high, random or held low per test phase.
module tb_decrypt_stream;

    typedef struct packed {
        logic [255:0] d;
        logic [31:0]  s;
        logic [127:0] u;
        logic         l;
        logic [31:0]  cyc;
    } ent_t;

    logic         axi_aclk = 1'b0;
    logic         axi_areset = 1'b1;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tstrb;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tready;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tstrb;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready = 1'b0;
    logic [31:0]  key;
    logic         decrypt_en;
    logic [31:0]  pkt_count;
    logic [31:0]  word_count;

    int           compared = 0;
    int           mismatched = 0;
    int unsigned  cyc = 0;
    int           bp_mode = 0;
    bit           lat_chk = 0;
    bit           use_ovr = 0;
    int           exp_words = 0;
    int           exp_pkts = 0;
    ent_t         sbq[$];

    logic [255:0] p_dat[8];
    logic [255:0] p_exp[8];
    logic [31:0]  p_strb[8];
    logic [127:0] p_usr[8];
    logic [255:0] orig[4];

    decrypt_stream dut (
        .axi_aclk      (axi_aclk),
        .axi_areset    (axi_areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .key           (key),
        .decrypt_en    (decrypt_en),
        .pkt_count     (pkt_count),
        .word_count    (word_count)
    );

    always #5 axi_aclk = ~axi_aclk;
    always @(posedge axi_aclk) cyc++;

    // Sink ready: 0 = always ready, 1 = random, otherwise held low.
    always @(posedge axi_aclk) begin
        #2;
        case (bp_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = 1'($urandom_range(0, 1));
            default: m_axis_tready = 1'b0;
        endcase
    end

    // Reference: word 0 untouched; word 1 XORs bits 0..239 with a keystream whose
    // low 16 bits are key[15:0] and whose key copies restart at bit 16; later words
    // XOR every bit b with key[b mod 32].
    function automatic logic [255:0] ref_word(input logic [255:0] d, input int idx,
                                              input logic [31:0] k, input logic e);
        logic [255:0] r;
        r = d;
        if (e && idx == 1) begin
            for (int b = 0; b < 240; b++) r[b] = d[b] ^ k[(b < 16) ? b : (b - 16) % 32];
        end else if (e && idx >= 2) begin
            for (int b = 0; b < 256; b++) r[b] = d[b] ^ k[b % 32];
        end
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Sends words 0..n_stop-1 of an n-word packet; key/en switch to k_mid/e_mid after word 0.
    task automatic send_pkt(input int n, input int n_stop, input logic [31:0] k, input logic e,
                            input logic [31:0] k_mid, input logic e_mid);
        ent_t en;
        int   w;
        key        = k;
        decrypt_en = e;
        for (int i = 0; i < n_stop; i++) begin
            s_axis_tdata  = p_dat[i];
            s_axis_tstrb  = p_strb[i];
            s_axis_tuser  = p_usr[i];
            s_axis_tlast  = (i == n - 1);
            s_axis_tvalid = 1'b1;
            w = 0;
            @(negedge axi_aclk);
            while (!s_axis_tready && w < 200) begin
                w++;
                @(negedge axi_aclk);
            end
            if (!s_axis_tready) begin
                compared++;
                mismatched++;
                $display("FAIL send_timeout: s_axis_tready stayed 0 for %0d cycles, required 1", w);
                s_axis_tvalid = 1'b0;
                return;
            end
            en.d   = use_ovr ? p_exp[i] : ref_word(p_dat[i], i, k, e);
            en.s   = p_strb[i];
            en.u   = p_usr[i];
            en.l   = (i == n - 1);
            en.cyc = cyc;
            sbq.push_back(en);
            @(posedge axi_aclk);
            #1;
            if (i == 0) begin
                key        = k_mid;
                decrypt_en = e_mid;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (n_stop == n) begin
            exp_words += n;
            if (e) exp_pkts++;
        end
    endtask

    task automatic drain_and_count(input string nm);
        int w;
        w = 0;
        while (sbq.size() != 0 && w < 1000) begin
            @(posedge axi_aclk);
            w++;
        end
        if (sbq.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s_drain: %0d words still expected, required 0", nm, sbq.size());
            sbq.delete();
        end
        repeat (2) @(posedge axi_aclk);
        #1;
        chk({nm, "_word_count"}, 256'(word_count), 256'(exp_words));
        chk({nm, "_pkt_count"}, 256'(pkt_count), 256'(exp_pkts));
    endtask

    // Monitor: pops the scoreboard on each m_axis handshake and checks output hold while stalled.
    logic         stall = 1'b0;
    logic [255:0] h_dat;
    logic [160:0] h_side;
    always @(negedge axi_aclk) begin
        ent_t e;
        if (axi_areset) begin
            stall = 1'b0;
        end else begin
            if (stall && m_axis_tvalid) begin
                chk("stable_tdata", m_axis_tdata, h_dat);
                chk("stable_side", 256'({m_axis_tstrb, m_axis_tuser, m_axis_tlast}), 256'(h_side));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (sbq.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_word: got %h with nothing outstanding", m_axis_tdata);
                end else begin
                    e = sbq.pop_front();
                    chk("tdata", m_axis_tdata, e.d);
                    chk("tstrb", 256'(m_axis_tstrb), 256'(e.s));
                    chk("tuser", 256'(m_axis_tuser), 256'(e.u));
                    chk("tlast", 256'(m_axis_tlast), 256'(e.l));
                    if (lat_chk) chk("latency", 256'(cyc - e.cyc), 256'd1);
                end
            end
            stall  = m_axis_tvalid && !m_axis_tready;
            h_dat  = m_axis_tdata;
            h_side = {m_axis_tstrb, m_axis_tuser, m_axis_tlast};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic [31:0] k;
        int n;

        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        key           = '0;
        decrypt_en    = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge axi_aclk);
        #1;
        chk("rst_s_tready", 256'(s_axis_tready), 256'd0);
        chk("rst_m_tvalid", 256'(m_axis_tvalid), 256'd0);
        chk("rst_m_tdata", m_axis_tdata, 256'd0);
        chk("rst_m_side", 256'({m_axis_tstrb, m_axis_tuser, m_axis_tlast}), 256'd0);
        chk("rst_counts", 256'({pkt_count, word_count}), 256'd0);
        @(negedge axi_aclk);
        axi_areset = 1'b0;
        #1;
        chk("tready_before_edge", 256'(s_axis_tready), 256'd0);
        @(negedge axi_aclk);
        chk("tready_after_edge", 256'(s_axis_tready), 256'd1);
        @(posedge axi_aclk);
        #1;

        // ---- all-ones key over zero data ----
        lat_chk = 1;
        use_ovr = 1;
        for (int i = 0; i < 3; i++) begin
            p_dat[i]  = '0;
            p_strb[i] = 32'hFFFF_FFFF;
            p_usr[i]  = 128'(i + 7);
        end
        p_exp[0] = '0;
        p_exp[1] = {16'h0000, {240{1'b1}}};
        p_exp[2] = {256{1'b1}};
        send_pkt(3, 3, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
        drain_and_count("ones_key");

        // ---- round trip through the encryption transform ----
        for (int i = 0; i < 4; i++) begin
            orig[i]   = {8{32'h0123_4567 + 32'(i * 32'h1111_1111)}};
            p_exp[i]  = orig[i];
            p_dat[i]  = ref_word(orig[i], i, 32'hA5A5_0F0F, 1'b1);
            p_strb[i] = (i == 3) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            p_usr[i]  = {4{32'hC0DE_0000 + 32'(i)}};
        end
        send_pkt(4, 4, 32'hA5A5_0F0F, 1'b1, 32'hA5A5_0F0F, 1'b1);
        drain_and_count("round_trip");

        // ---- pass-through ----
        for (int i = 0; i < 3; i++) begin
            p_dat[i] = 256'(i + 1);
            p_exp[i] = 256'(i + 1);
        end
        send_pkt(3, 3, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0);
        drain_and_count("bypass");
        use_ovr = 0;
        lat_chk = 0;

        // ---- sink stalled for 5 cycles under a 6-word burst ----
        for (int i = 0; i < 6; i++) begin
            p_dat[i]  = rand256();
            p_strb[i] = $urandom;
            p_usr[i]  = {$urandom, $urandom, $urandom, $urandom};
        end
        k = $urandom;
        bp_mode = 2;
        acc = 0;
        fork
            send_pkt(6, 6, k, 1'b1, k, 1'b1);
            begin
                for (int c = 0; c < 5; c++) begin
                    @(negedge axi_aclk);
                    if (s_axis_tvalid && s_axis_tready) acc++;
                    if (c >= 2) chk("stall_tready_low", 256'(s_axis_tready), 256'd0);
                end
                bp_mode = 0;
            end
        join
        chk("stall_accepted", 256'(acc), 256'd2);
        drain_and_count("stall");

        // ---- key change mid-packet, then next packet, then 1-word packet ----
        for (int i = 0; i < 3; i++) p_dat[i] = rand256();
        send_pkt(3, 3, 32'h1, 1'b1, 32'h2, 1'b0);
        for (int i = 0; i < 3; i++) p_dat[i] = rand256();
        send_pkt(3, 3, 32'h2, 1'b1, 32'h2, 1'b1);
        p_dat[0] = rand256();
        send_pkt(1, 1, 32'h2, 1'b1, 32'h2, 1'b1);
        drain_and_count("key_change");

        // ---- randomized packets with random sink backpressure ----
        bp_mode = 1;
        for (int p = 0; p < 40; p++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                p_dat[i]  = rand256();
                p_strb[i] = $urandom;
                p_usr[i]  = {$urandom, $urandom, $urandom, $urandom};
            end
            send_pkt(n, n, $urandom, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge axi_aclk);
            #1;
        end
        bp_mode = 0;
        drain_and_count("random");

        // ---- reset between word 2 and word 3 ----
        for (int i = 0; i < 3; i++) p_dat[i] = rand256();
        send_pkt(3, 2, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1);
        axi_areset = 1'b1;
        sbq.delete();
        #1;
        chk("midrst_m_tvalid", 256'(m_axis_tvalid), 256'd0);
        chk("midrst_m_tdata", m_axis_tdata, 256'd0);
        chk("midrst_counts", 256'({pkt_count, word_count}), 256'd0);
        repeat (2) @(negedge axi_aclk);
        axi_areset = 1'b0;
        exp_words = 0;
        exp_pkts  = 0;
        @(posedge axi_aclk);
        #1;
        for (int i = 0; i < 3; i++) p_dat[i] = rand256();
        send_pkt(3, 3, 32'h0BAD_CAFE, 1'b1, 32'h0BAD_CAFE, 1'b1);
        drain_and_count("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/decrypt_stream.md
# decrypt_stream

AXI4-Stream decryption stage for the NetFPGA-10G user data path; the receive-side counterpart of the packet encryption stage. It strips the 32-bit XOR keystream from each packet by XORing header word 2 (below bit 240) and all payload words with the key, and passes header word 1 and the top 16 bits of word 2 unchanged. Output is registered through a 2-entry skid buffer so `s_axis_tready` carries no combinational path from `m_axis_tready`. A per-packet key/enable latch and packet/word counters are exposed for the register block.

## Interface
- C_M_AXIS_DATA_WIDTH, 256, master tdata width (fixed at 256; other values unsupported)
- C_S_AXIS_DATA_WIDTH, 256, slave tdata width (must equal master)
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width
- C_S_AXI_DATA_WIDTH, 32, key/counter register width

- axi_aclk  in  1  sole clock, all logic rising-edge
- axi_areset  in  1  asynchronous, active-high reset
- s_axis_tdata/tstrb/tuser/tvalid/tlast  in  256/32/128/1/1  upstream stream
- s_axis_tready  out  1  upstream ready
- m_axis_tdata/tstrb/tuser/tvalid/tlast  out  256/32/128/1/1  downstream stream
- m_axis_tready  in  1  downstream ready
- key  in  32  decryption key (software register)
- decrypt_en  in  1  1 = decrypt, 0 = pass-through
- pkt_count  out  32  packets emitted with decryption applied
- word_count  out  32  total words emitted on m_axis

## Operation
- Input FSM advances on each s_axis handshake (tvalid & tready): HDR1 -> HDR2 -> PAYLOAD. Any handshake with tlast returns to HDR1, from any state.
- On a handshake in HDR1, latch `key` into key_q and `decrypt_en` into en_q; these stay fixed for the whole packet. Mid-packet changes to `key`/`decrypt_en` take effect only on the next packet.
- Transform applied at accept time (en_q or freshly latched value for HDR1):
  - HDR1: tdata unchanged.
  - HDR2: out[255:240] = in[255:240]; out[239:0] = in[239:0] ^ {7{key_q}, key_q[15:0]}.
  - PAYLOAD: out = in ^ {8{key_q}}.
  - When en = 0: tdata unchanged in every state.
- tstrb, tuser, tlast are forwarded unmodified. tstrb does not gate the XOR: bytes with tstrb = 0 are XORed too.
- Output buffer holds 2 entries, main and skid, with a registered occupancy of 0..2.
  - s_axis_tready = (occupancy != 2).
  - m_axis_tvalid = (occupancy != 0).
  - Order is strictly FIFO.
- Counters:
  - word_count increments on every m_axis handshake.
  - pkt_count increments on an m_axis handshake with tlast when that packet's en was 1.
  - Both wrap at 2^32 to 0 without saturation.
- 1-word packets: single word is HDR1, passed unchanged; FSM stays in HDR1.
- 2-word packets: word 2 is treated as HDR2.

## Timing
- Reset values: s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tdata/tstrb/tuser/tlast = 0, pkt_count = 0, word_count = 0, FSM = HDR1, key_q = 0, en_q = 0, occupancy = 0.
- s_axis_tready rises on the first clock edge after reset deasserts.
- Latency: a word accepted at edge N is presented on m_axis after edge N, in cycle N+1.
- Throughput: 1 word/cycle while m_axis_tready stays high.
- Backpressure: with m_axis_tready low, at most 2 words are accepted before s_axis_tready drops. s_axis_tready returns high the cycle after the next m_axis handshake.
- Simultaneous s and m handshakes in one cycle leave occupancy unchanged.
- m_axis_tdata/tuser/tstrb/tlast must stay stable while m_axis_tvalid = 1 and m_axis_tready = 0.
- Reset asserted mid-packet: both buffer entries are discarded, FSM returns to HDR1, counters clear, outputs take reset values immediately (asynchronous). No partial packet is emitted after reset.

## Test plan
- Key 32'hFFFFFFFF, en = 1, 3-word packet of all-zero tdata, m_axis_tready = 1 -> out word1 = 0; word2 = {16'h0000, 240 bits of 1}; word3 = all-ones; outputs appear 1 cycle after input; pkt_count = 1, word_count = 3.
- Round trip: encrypt known 4-word packet with key 32'hA5A5_0F0F through the encryption stage, then feed it to this block with the same key -> output bit-identical to the original 4-word packet, including tuser, tstrb and tlast.
- en = 0, key 32'h12345678, 3-word packet 256'h1..3 -> output tdata unchanged; word_count = 3, pkt_count = 0.
- m_axis_tready held 0 for 5 cycles during a continuous 6-word input -> exactly 2 words accepted, s_axis_tready = 0 from the 3rd cycle on, no word lost or reordered after tready is released, output data stable while stalled.
- Key changed from 32'h1 to 32'h2 during word 2 of packet A, then packet B sent -> all of A decrypted with 32'h1, B with 32'h2; a 1-word packet C is passed unchanged.
- axi_areset pulsed between word 2 and word 3 of a packet, then a new 3-word packet sent -> no stale word emitted; counters restart from 0; new packet decoded starting in HDR1.
